// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory: access sizes, lane strobes
// and alignment rules.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_e;

   function automatic logic [WORD_BYTES-1:0] strobe(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
      case (size)
         MEM_BYTE: return 4'b0001 << addr_lo;
         MEM_HALF: return 4'b0011 << addr_lo;
         MEM_WORD: return 4'b1111;
         default:  return 4'b0000;
      endcase
   endfunction

   function automatic logic align_ok(input logic [1:0] size,
                                     input logic [1:0] addr_lo);
      case (size)
         MEM_BYTE: return 1'b1;
         MEM_HALF: return ~addr_lo[0];
         MEM_WORD: return addr_lo == 2'b00;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// LATENCY-stage {valid, err, data} delay line for read responses.
// Data is only loaded alongside a valid beat, so the output holds between responses.
module mem_rd_pipe #(
   parameter int LATENCY = 1,
   parameter int WIDTH   = 32
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             in_valid,
   input  logic             in_err,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             out_err,
   output logic [WIDTH-1:0] out_data
);

   logic [LATENCY-1:0] valid_reg, err_reg;
   logic [LATENCY-1:0] valid_next, err_next;
   logic [WIDTH-1:0]   data_reg  [LATENCY];
   logic [WIDTH-1:0]   data_next [LATENCY];

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign valid_next[gi] = in_valid;
            assign err_next[gi]   = in_valid & in_err;
            assign data_next[gi]  = in_data;
         end else begin : g_body
            assign valid_next[gi] = valid_reg[gi-1];
            assign err_next[gi]   = err_reg[gi-1];
            assign data_next[gi]  = data_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         valid_reg <= '0;
         err_reg   <= '0;
         for (int i = 0; i < LATENCY; i++) data_reg[i] <= '0;
      end else begin
         valid_reg <= valid_next;
         err_reg   <= err_next;
         for (int i = 0; i < LATENCY; i++) begin
            if (valid_next[i]) data_reg[i] <= data_next[i];
         end
      end
   end

   assign out_valid = valid_reg[LATENCY-1];
   assign out_err   = err_reg[LATENCY-1];
   assign out_data  = data_reg[LATENCY-1];

endmodule

// File: rtl/riscv_data_mem.sv
// Data memory for the core's load/store port: byte/half/word stores with lane
// strobes, pipelined word reads, and range/alignment error reporting.
module riscv_data_mem
   import mem_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR    = '0,
   parameter int              READ_LATENCY = 1
) (
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic            mem_read_en_i,
   input  logic            mem_write_en_i,
   input  logic [1:0]      mem_size_i,
   input  logic [XLEN-1:0] mem_write_data_i,
   output logic [XLEN-1:0] mem_read_data_o,
   output logic            mem_read_valid_o,
   output logic            mem_err_o
);

   localparam int              IDX_W = $clog2(DEPTH);
   localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH * WORD_BYTES);

   logic [XLEN-1:0]       offset;
   logic [IDX_W-1:0]      word_idx;
   logic [1:0]            addr_lo;
   logic                  access_ok;
   logic                  rd_err, wr_err, wr_commit;
   logic [WORD_BYTES-1:0] wr_strb;
   logic [XLEN-1:0]       wr_word, rd_word;
   logic                  wr_err_reg;
   logic                  pipe_err;
   logic [XLEN-1:0]       mem_array [DEPTH];

   // BASE_ADDR is span-aligned, so the low address bits equal the offset's.
   assign offset    = mem_addr_i - BASE_ADDR;
   assign word_idx  = offset[IDX_W+1:2];
   assign addr_lo   = mem_addr_i[1:0];
   assign access_ok = (offset < SPAN) & align_ok(mem_size_i, addr_lo);

   // Both enables together is reported as a failed read and never writes.
   assign rd_err    = mem_read_en_i & (mem_write_en_i | ~access_ok);
   assign wr_err    = mem_write_en_i & ~mem_read_en_i & ~access_ok;
   assign wr_commit = mem_write_en_i & ~mem_read_en_i & access_ok;
   assign wr_strb   = strobe(mem_size_i, addr_lo);

   always_comb begin
      wr_word = mem_write_data_i;
      case (mem_size_i)
         MEM_BYTE: wr_word = {WORD_BYTES{mem_write_data_i[7:0]}};
         MEM_HALF: wr_word = {(WORD_BYTES/2){mem_write_data_i[15:0]}};
         default:  wr_word = mem_write_data_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (wr_commit) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_strb[b]) mem_array[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
         end
      end
   end

   assign rd_word = rd_err ? '0 : mem_array[word_idx];

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) wr_err_reg <= 1'b0;
      else           wr_err_reg <= wr_err;
   end

   mem_rd_pipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (XLEN)
   ) u_rd_pipe (
      .clk_i     (clk_i),
      .resetn_i  (resetn_i),
      .in_valid  (mem_read_en_i),
      .in_err    (rd_err),
      .in_data   (rd_word),
      .out_valid (mem_read_valid_o),
      .out_err   (pipe_err),
      .out_data  (mem_read_data_o)
   );

   assign mem_err_o = pipe_err | wr_err_reg;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench: a READ_LATENCY=1 and a READ_LATENCY=3 instance share one stimulus stream.
module tb_riscv_data_mem;
   import mem_pkg::*;

   logic        clk_i    = 1'b0;
   logic        resetn_i = 1'b0;
   logic [31:0] addr     = '0;
   logic        re       = 1'b0;
   logic        we       = 1'b0;
   logic [1:0]  size     = 2'd0;
   logic [31:0] wdata    = '0;

   logic [31:0] l1_data, l3_data;
   logic        l1_valid, l1_err, l3_valid, l3_err;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   riscv_data_mem #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u_l1 (
      .clk_i            (clk_i),
      .resetn_i         (resetn_i),
      .mem_addr_i       (addr),
      .mem_read_en_i    (re),
      .mem_write_en_i   (we),
      .mem_size_i       (size),
      .mem_write_data_i (wdata),
      .mem_read_data_o  (l1_data),
      .mem_read_valid_o (l1_valid),
      .mem_err_o        (l1_err)
   );

   riscv_data_mem #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u_l3 (
      .clk_i            (clk_i),
      .resetn_i         (resetn_i),
      .mem_addr_i       (addr),
      .mem_read_en_i    (re),
      .mem_write_en_i   (we),
      .mem_size_i       (size),
      .mem_write_data_i (wdata),
      .mem_read_data_o  (l3_data),
      .mem_read_valid_o (l3_valid),
      .mem_err_o        (l3_err)
   );

   typedef struct {
      logic        re;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        xv;
      logic        xe;
      logic [31:0] xd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic xv, input logic xe, input logic [31:0] xd);
      vec_t v;
      v.re = r; v.we = w; v.size = s; v.addr = a; v.wdata = d;
      v.xv = xv; v.xe = xe; v.xd = xd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      re = r; we = w; size = s; addr = a; wdata = d;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      check("rst.l1_valid", 32'(l1_valid), 32'd0);
      check("rst.l1_err",   32'(l1_err),   32'd0);
      check("rst.l1_data",  l1_data,       32'd0);
      check("rst.l3_valid", 32'(l3_valid), 32'd0);
      check("rst.l3_err",   32'(l3_err),   32'd0);
      check("rst.l3_data",  l3_data,       32'd0);
      resetn_i = 1'b1;
      tick();

      vecs.push_back(mk(0, 1, 2'd2, 32'h10,  32'hA0A0_8080, 0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'hA0A0_8080));
      vecs.push_back(mk(0, 1, 2'd0, 32'h13,  32'h48,        0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'h48A0_8080));
      vecs.push_back(mk(0, 1, 2'd1, 32'h12,  32'h1234,      0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'h1234_8080));
      vecs.push_back(mk(0, 1, 2'd1, 32'h11,  32'hFFFF,      0, 1, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'h1234_8080));
      vecs.push_back(mk(1, 0, 2'd2, 32'h1000, 32'h0,        1, 1, 32'h0));
      vecs.push_back(mk(1, 1, 2'd2, 32'h10,  32'hFFFF_FFFF, 1, 1, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'h1234_8080));
      vecs.push_back(mk(1, 0, 2'd0, 32'h13,  32'h0,         1, 0, 32'h1234_8080));
      vecs.push_back(mk(1, 0, 2'd1, 32'h13,  32'h0,         1, 1, 32'h0));
      vecs.push_back(mk(1, 0, 2'd3, 32'h10,  32'h0,         1, 1, 32'h0));
      vecs.push_back(mk(0, 1, 2'd3, 32'h10,  32'h0,         0, 1, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h10,  32'h0,         1, 0, 32'h1234_8080));
      vecs.push_back(mk(0, 1, 2'd2, 32'h14,  32'h0,         0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 2'd1, 32'h16,  32'hFFFF_5678, 0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h14,  32'h0,         1, 0, 32'h5678_0000));
      vecs.push_back(mk(0, 1, 2'd0, 32'h15,  32'h0000_00AB, 0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'h14,  32'h0,         1, 0, 32'h5678_AB00));
      vecs.push_back(mk(0, 1, 2'd2, 32'hFFC, 32'hDEAD_BEEF, 0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 2'd2, 32'hFFC, 32'h0,         1, 0, 32'hDEAD_BEEF));
      vecs.push_back(mk(1, 0, 2'd2, 32'hFFFF_FFFC, 32'h0,   1, 1, 32'h0));
      vecs.push_back(mk(0, 1, 2'd2, 32'h0,   32'h1,         0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 2'd2, 32'h4,   32'h2,         0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 2'd2, 32'h8,   32'h3,         0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 2'd2, 32'h0,   32'h0,         0, 0, 32'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].re, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         tick();
         $display("vec %0d re=%0b we=%0b size=%0d addr=%h wdata=%h -> valid=%0b err=%0b data=%h",
                  i, vecs[i].re, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                  l1_valid, l1_err, l1_data);
         check($sformatf("v%0d.valid", i), 32'(l1_valid), 32'(vecs[i].xv));
         check($sformatf("v%0d.err", i),   32'(l1_err),   32'(vecs[i].xe));
         if (vecs[i].xv) check($sformatf("v%0d.data", i), l1_data, vecs[i].xd);
      end

      drive(0, 0, 2'd0, 32'h0, 32'h0);
      repeat (4) tick();

      // Store error pulses one cycle after the request even with a longer read latency
      drive(0, 1, 2'd1, 32'h11, 32'hFFFF);
      tick();
      $display("l3 misaligned SH 0x11 -> err=%0b", l3_err);
      check("l3.wr_err_pulse", 32'(l3_err), 32'd1);
      drive(0, 0, 2'd0, 32'h0, 32'h0);
      tick();
      check("l3.wr_err_clear", 32'(l3_err), 32'd0);
      repeat (3) tick();

      // Back-to-back reads through the 3-stage pipeline
      for (int k = 0; k < 6; k++) begin
         if (k < 3) drive(1, 0, 2'd2, 32'(4 * k), 32'h0);
         else       drive(0, 0, 2'd0, 32'h0, 32'h0);
         tick();
         $display("l3 burst cycle %0d -> valid=%0b err=%0b data=%h", k, l3_valid, l3_err, l3_data);
         check($sformatf("burst%0d.valid", k), 32'(l3_valid), 32'((k >= 2 && k <= 4) ? 1 : 0));
         check($sformatf("burst%0d.err", k), 32'(l3_err), 32'd0);
         if (k >= 2 && k <= 4) check($sformatf("burst%0d.data", k), l3_data, 32'(k - 1));
      end
      repeat (3) tick();

      // Asynchronous reset with reads in flight
      drive(1, 0, 2'd2, 32'h4, 32'h0);
      tick();
      drive(1, 0, 2'd2, 32'h8, 32'h0);
      tick();
      drive(0, 0, 2'd0, 32'h0, 32'h0);
      tick();
      check("rr.pre_valid", 32'(l3_valid), 32'd1);
      check("rr.pre_data",  l3_data,       32'd2);
      #2;
      resetn_i = 1'b0;
      #1;
      $display("l3 async reset -> valid=%0b err=%0b data=%h", l3_valid, l3_err, l3_data);
      check("rr.async_valid", 32'(l3_valid), 32'd0);
      check("rr.async_data",  l3_data,       32'd0);
      check("rr.async_err",   32'(l3_err),   32'd0);
      @(posedge clk_i);
      #1;
      resetn_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rr.drain%0d", k), {30'd0, l3_valid, l3_err}, 32'd0);
      end
      drive(1, 0, 2'd2, 32'h8, 32'h0);
      tick();
      drive(0, 0, 2'd0, 32'h0, 32'h0);
      tick();
      check("rr.reread_early", 32'(l3_valid), 32'd0);
      tick();
      $display("l3 re-read 0x8 -> valid=%0b err=%0b data=%h", l3_valid, l3_err, l3_data);
      check("rr.reread_valid", 32'(l3_valid), 32'd1);
      check("rr.reread_data",  l3_data,       32'd3);
      check("rr.reread_err",   32'(l3_err),   32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
